// File: rtl/instr_decoder_pkg.sv
// Shared MIPS decode constants: opcode/funct/COP0-rs encodings, control enums,
// exception codes and instruction field slices.
package instr_decoder_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;
  localparam logic [5:0] FN_ERET    = 6'h18;

  localparam logic [4:0] RS_MF      = 5'h00;
  localparam logic [4:0] RS_MT      = 5'h04;
  localparam logic [4:0] RS_ERET    = 5'h10;

  localparam logic [4:0] EXC_NONE    = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } md_op_e;

  typedef enum logic [2:0] {
    JMP_PC4, JMP_BEQ, JMP_BNE, JMP_JAL, JMP_JR, JMP_ERET
  } jump_op_e;

  typedef enum logic [2:0] {
    EXT_ZERO, EXT_SIGN, EXT_LUI
  } ext_ctrl_e;

  typedef enum logic [1:0] {
    DM_Word32, DM_HalfWord16, DM_Byte8
  } dm_len_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] i);
    return i[31:26];
  endfunction
  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[15:11];
  endfunction
  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction
  function automatic logic [15:0] f_imm(input logic [31:0] i);
    return i[15:0];
  endfunction
  function automatic logic [15:0] f_offset(input logic [31:0] i);
    return i[15:0];
  endfunction
  function automatic logic [25:0] f_index(input logic [31:0] i);
    return i[25:0];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Per-stage MIPS instruction decoder: combinational controls from instr, plus a
// reset-released run flag that drives all pipeline-register enables.
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic        A3FromRt,
  output logic        WDFromDM,
  output logic        MemWrite,
  output logic [1:0]  len,
  output logic        SrcBFromExt,
  output logic [2:0]  ExtCtrl,
  output logic [3:0]  ALUOp,
  output logic [3:0]  MDOp,
  output logic        start,
  output logic [2:0]  JumpOp,
  output logic        CalReg,
  output logic        CalImm,
  output logic        Load,
  output logic        Store,
  output logic        JR,
  output logic        Link,
  output logic        MD,
  output logic        Load_HILO,
  output logic        Store_HILO,
  output logic        Jump,
  output logic        MFC0,
  output logic        ERET,
  output logic        CP0Write,
  output logic        newinstr,
  output logic        BDins,
  output logic [4:0]  ExcCode,
  output logic        IF_IDEN,
  output logic        ID_EXEN,
  output logic        EX_MEMEN,
  output logic        MEM_WBEN
);

  logic      run;
  logic      reg_write_raw, mem_write_raw, cp0_write_raw, start_raw;
  logic      exc_ok;
  alu_op_e   alu;
  md_op_e    mdo;
  jump_op_e  jop;
  ext_ctrl_e ext;
  dm_len_e   dlen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign IF_IDEN  = run;
  assign ID_EXEN  = run;
  assign EX_MEMEN = run;
  assign MEM_WBEN = run;

  always_comb begin
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    cp0_write_raw = 1'b0;
    start_raw     = 1'b0;
    A3FromRt      = 1'b0;
    WDFromDM      = 1'b0;
    SrcBFromExt   = 1'b0;
    CalReg = 1'b0; CalImm = 1'b0; Load = 1'b0; Store = 1'b0;
    JR = 1'b0; Link = 1'b0; MD = 1'b0; Load_HILO = 1'b0; Store_HILO = 1'b0;
    Jump = 1'b0; MFC0 = 1'b0; ERET = 1'b0; BDins = 1'b0;
    alu     = ALU_ADD;
    mdo     = MD_NONE;
    jop     = JMP_PC4;
    ext     = EXT_ZERO;
    dlen    = DM_Word32;
    ExcCode = EXC_NONE;
    // Only the all-zero word is accepted as a shift (nop); other sll encodings trap.
    if (instr != 32'h0) begin
      case (f_opcode(instr))
        OP_SPECIAL: begin
          case (f_funct(instr))
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
              CalReg        = 1'b1;
              reg_write_raw = 1'b1;
              case (f_funct(instr))
                FN_SUB:  alu = ALU_SUB;
                FN_AND:  alu = ALU_AND;
                FN_OR:   alu = ALU_OR;
                FN_SLT:  alu = ALU_SLT;
                FN_SLTU: alu = ALU_SLTU;
                default: alu = ALU_ADD;
              endcase
            end
            FN_MULT:  begin MD = 1'b1; start_raw = 1'b1; mdo = MD_MULT;  end
            FN_MULTU: begin MD = 1'b1; start_raw = 1'b1; mdo = MD_MULTU; end
            FN_DIV:   begin MD = 1'b1; start_raw = 1'b1; mdo = MD_DIV;   end
            FN_DIVU:  begin MD = 1'b1; start_raw = 1'b1; mdo = MD_DIVU;  end
            FN_MFHI:  begin Load_HILO = 1'b1; reg_write_raw = 1'b1; mdo = MD_MFHI; end
            FN_MFLO:  begin Load_HILO = 1'b1; reg_write_raw = 1'b1; mdo = MD_MFLO; end
            FN_MTHI:  begin Store_HILO = 1'b1; mdo = MD_MTHI; end
            FN_MTLO:  begin Store_HILO = 1'b1; mdo = MD_MTLO; end
            FN_JR:    begin JR = 1'b1; Jump = 1'b1; jop = JMP_JR; BDins = 1'b1; end
            FN_SYSCALL: ExcCode = EXC_SYSCALL;
            default:    ExcCode = EXC_RI;
          endcase
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
          CalImm        = 1'b1;
          reg_write_raw = 1'b1;
          A3FromRt      = 1'b1;
          SrcBFromExt   = 1'b1;
          case (f_opcode(instr))
            OP_ADDI: begin ext = EXT_SIGN; alu = ALU_ADD; end
            OP_ANDI: begin ext = EXT_ZERO; alu = ALU_AND; end
            OP_ORI:  begin ext = EXT_ZERO; alu = ALU_OR;  end
            default: begin ext = EXT_LUI;  alu = ALU_LUI; end
          endcase
        end
        OP_LB, OP_LH, OP_LW: begin
          Load          = 1'b1;
          reg_write_raw = 1'b1;
          A3FromRt      = 1'b1;
          WDFromDM      = 1'b1;
          SrcBFromExt   = 1'b1;
          ext           = EXT_SIGN;
          dlen = (f_opcode(instr) == OP_LB) ? DM_Byte8 :
                 (f_opcode(instr) == OP_LH) ? DM_HalfWord16 : DM_Word32;
        end
        OP_SB, OP_SH, OP_SW: begin
          Store         = 1'b1;
          mem_write_raw = 1'b1;
          SrcBFromExt   = 1'b1;
          ext           = EXT_SIGN;
          dlen = (f_opcode(instr) == OP_SB) ? DM_Byte8 :
                 (f_opcode(instr) == OP_SH) ? DM_HalfWord16 : DM_Word32;
        end
        OP_BEQ: begin jop = JMP_BEQ; ext = EXT_SIGN; BDins = 1'b1; end
        OP_BNE: begin jop = JMP_BNE; ext = EXT_SIGN; BDins = 1'b1; end
        OP_JAL: begin
          Link = 1'b1; Jump = 1'b1; reg_write_raw = 1'b1; jop = JMP_JAL; BDins = 1'b1;
        end
        OP_COP0: begin
          if (f_rs(instr) == RS_MF) begin
            MFC0 = 1'b1; reg_write_raw = 1'b1; A3FromRt = 1'b1;
          end else if (f_rs(instr) == RS_MT) begin
            cp0_write_raw = 1'b1;
          end else if (f_rs(instr) == RS_ERET && f_funct(instr) == FN_ERET) begin
            ERET = 1'b1; jop = JMP_ERET;
          end else begin
            ExcCode = EXC_RI;
          end
        end
        default: ExcCode = EXC_RI;
      endcase
    end
  end

  // A trapping instruction must never commit architectural state.
  assign exc_ok   = (ExcCode == EXC_NONE);
  assign RegWrite = reg_write_raw & exc_ok;
  assign MemWrite = mem_write_raw & exc_ok;
  assign CP0Write = cp0_write_raw & exc_ok;
  assign start    = start_raw & exc_ok;

  assign ALUOp    = alu;
  assign MDOp     = mdo;
  assign JumpOp   = jop;
  assign ExtCtrl  = ext;
  assign len      = dlen;
  assign newinstr = 1'b0;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: reference decode model feeds an expected queue that is
// drained against the DUT's packed controls; enable flag checked around resets.
module tb_instr_decoder;

  localparam int W = 42;

  logic        clk, reset;
  logic [31:0] instr;
  logic        RegWrite, A3FromRt, WDFromDM, MemWrite, SrcBFromExt, start;
  logic [1:0]  len;
  logic [2:0]  ExtCtrl, JumpOp;
  logic [3:0]  ALUOp, MDOp;
  logic        CalReg, CalImm, Load, Store, JR, Link, MD, Load_HILO, Store_HILO;
  logic        Jump, MFC0, ERET, CP0Write, newinstr, BDins;
  logic [4:0]  ExcCode;
  logic        IF_IDEN, ID_EXEN, EX_MEMEN, MEM_WBEN;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  instr_decoder dut (
    .clk(clk), .reset(reset), .instr(instr),
    .RegWrite(RegWrite), .A3FromRt(A3FromRt), .WDFromDM(WDFromDM), .MemWrite(MemWrite),
    .len(len), .SrcBFromExt(SrcBFromExt), .ExtCtrl(ExtCtrl), .ALUOp(ALUOp), .MDOp(MDOp),
    .start(start), .JumpOp(JumpOp), .CalReg(CalReg), .CalImm(CalImm), .Load(Load),
    .Store(Store), .JR(JR), .Link(Link), .MD(MD), .Load_HILO(Load_HILO),
    .Store_HILO(Store_HILO), .Jump(Jump), .MFC0(MFC0), .ERET(ERET), .CP0Write(CP0Write),
    .newinstr(newinstr), .BDins(BDins), .ExcCode(ExcCode),
    .IF_IDEN(IF_IDEN), .ID_EXEN(ID_EXEN), .EX_MEMEN(EX_MEMEN), .MEM_WBEN(MEM_WBEN)
  );

  wire [W-1:0] dut_vec = {RegWrite, A3FromRt, WDFromDM, MemWrite, len, SrcBFromExt,
                          ExtCtrl, ALUOp, MDOp, start, JumpOp,
                          CalReg, CalImm, Load, Store, JR, Link, MD, Load_HILO,
                          Store_HILO, Jump, MFC0, ERET, CP0Write, newinstr, BDins, ExcCode};
  wire [3:0] en = {IF_IDEN, ID_EXEN, EX_MEMEN, MEM_WBEN};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // reference decode
  function automatic logic [W-1:0] model(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, exc;
    logic rw, a3, wd, mw, sb, st, cr, ci, ld, so, jr, lk, md, lhl, shl, jp, mf, er, cw, bd;
    logic [1:0] ln;
    logic [2:0] ex, jo;
    logic [3:0] al, mo;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21];
    {rw, a3, wd, mw, sb, st, cr, ci, ld, so, jr, lk, md, lhl, shl, jp, mf, er, cw, bd} = '0;
    ln = 0; ex = 0; jo = 0; al = 0; mo = 0; exc = 0;
    if (w != 32'h0) begin
      if (op == 6'h00) begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B}) begin
          cr = 1; rw = 1;
          al = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
               (fn == 6'h25) ? 4'd3 : (fn == 6'h2A) ? 4'd4 : 4'd5;
        end else if (fn inside {[6'h18:6'h1B]}) begin
          md = 1; st = 1; mo = 4'(fn - 6'h18 + 6'd1);
        end else if (fn == 6'h10 || fn == 6'h12) begin
          lhl = 1; rw = 1; mo = (fn == 6'h10) ? 4'd5 : 4'd6;
        end else if (fn == 6'h11 || fn == 6'h13) begin
          shl = 1; mo = (fn == 6'h11) ? 4'd7 : 4'd8;
        end else if (fn == 6'h08) begin
          jr = 1; jp = 1; jo = 4; bd = 1;
        end else if (fn == 6'h0C) exc = 8;
        else exc = 10;
      end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) begin
        ci = 1; rw = 1; a3 = 1; sb = 1;
        case (op)
          6'h08:   begin ex = 1; al = 0; end
          6'h0C:   begin ex = 0; al = 2; end
          6'h0D:   begin ex = 0; al = 3; end
          default: begin ex = 2; al = 6; end
        endcase
      end else if (op inside {6'h20, 6'h21, 6'h23}) begin
        ld = 1; rw = 1; a3 = 1; wd = 1; sb = 1; ex = 1;
        ln = (op == 6'h20) ? 2'd2 : (op == 6'h21) ? 2'd1 : 2'd0;
      end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
        so = 1; mw = 1; sb = 1; ex = 1;
        ln = (op == 6'h28) ? 2'd2 : (op == 6'h29) ? 2'd1 : 2'd0;
      end else if (op == 6'h04 || op == 6'h05) begin
        jo = (op == 6'h04) ? 3'd1 : 3'd2; ex = 1; bd = 1;
      end else if (op == 6'h03) begin
        lk = 1; jp = 1; rw = 1; jo = 3; bd = 1;
      end else if (op == 6'h10) begin
        if (rs == 5'h00) begin mf = 1; rw = 1; a3 = 1; end
        else if (rs == 5'h04) cw = 1;
        else if (rs == 5'h10 && fn == 6'h18) begin er = 1; jo = 5; end
        else exc = 10;
      end else exc = 10;
    end
    return {rw, a3, wd, mw, ln, sb, ex, al, mo, st, jo,
            cr, ci, ld, so, jr, lk, md, lhl, shl, jp, mf, er, cw, 1'b0, bd, exc};
  endfunction

  // driver
  task automatic drive(input logic [31:0] w, input string t);
    @(posedge clk);
    #1;
    instr = w;
    exp_q.push_back(model(w));
    tag_q.push_back(t);
  endtask

  // scoreboard: outputs are combinational, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, 64'(dut_vec), 64'(e));
    end
  end

  logic [5:0] fn_list[17] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h18, 6'h19,
                              6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h08, 6'h0C, 6'h3F};
  logic [5:0] op_list[14] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h28,
                              6'h29, 6'h2B, 6'h04, 6'h05, 6'h03, 6'h02};
  logic [4:0] cop_rs[4]   = '{5'h00, 5'h04, 5'h10, 5'h08};

  initial begin
    logic [31:0] w;
    reset = 1'b0;
    instr = 32'h0;
    #3;
    check_val("en_in_reset", 64'(en), 64'h0);
    drive(32'h00000000, "nop");
    drive(32'h00221820, "add_in_reset");
    @(posedge clk); #1;
    check_val("en_held_reset", 64'(en), 64'h0);
    #2 reset = 1'b1;
    #1 check_val("en_no_edge", 64'(en), 64'h0);
    @(posedge clk); #1;
    check_val("en_run", 64'(en), 64'hF);

    drive(32'h00221820, "add");
    drive(32'h0022183F, "bad_funct");
    drive(32'h84450004, "lh");
    drive(32'hA0450004, "sb");
    drive(32'h10220003, "beq");
    drive(32'h0C000010, "jal");
    drive(32'h03E00008, "jr");
    drive(32'h0000000C, "syscall");
    drive(32'h40826000, "mtc0");
    drive(32'h42000018, "eret");
    drive(32'h40026000, "mfc0");
    drive(32'h2022FFFF, "addi");
    drive(32'h3C011234, "lui");
    drive(32'h00220018, "mult");
    drive(32'h00001810, "mfhi");
    drive(32'h00200013, "mtlo");
    drive(32'hFC000000, "bad_op");
    drive(32'h00000040, "sll_nonzero");

    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_val("en_async_clear", 64'(en), 64'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_val("en_rerun", 64'(en), 64'hF);

    for (int i = 0; i < 60; i++) begin
      w = $urandom();
      case ($urandom_range(0, 3))
        0: ;
        1: begin w[31:26] = 6'h00; w[5:0] = fn_list[$urandom_range(0, 16)]; end
        2: w[31:26] = op_list[$urandom_range(0, 13)];
        default: begin
          w[31:26] = 6'h10;
          w[25:21] = cop_rs[$urandom_range(0, 3)];
          if ($urandom_range(0, 1) == 1) w[5:0] = 6'h18;
        end
      endcase
      drive(w, $sformatf("rand_%08h", w));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #6;
    if (exp_q.size() != 0) check_val("queue_drain", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
